// File: rtl/param_loader_pkg.sv
// Shared types and constants for the parameter-fetch stage: FSM states,
// parameter word indices, field positions and legal kernel/stride values.
package param_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_FETCH,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE
  } param_loader_state_t;

  localparam int PW_DIMS0  = 0;
  localparam int PW_DIMS1  = 1;
  localparam int PW_CTRL   = 2;
  localparam int PW_QSHIFT = 3;
  localparam int PW_WBASE  = 4;
  localparam int PW_BBASE  = 5;
  localparam int PW_IBASE  = 6;
  localparam int PW_OBASE  = 7;

  localparam int F_DIM_LO_LSB = 0;
  localparam int F_DIM_HI_LSB = 16;
  localparam int F_KERNEL_LSB = 0;
  localparam int F_STRIDE_LSB = 4;
  localparam int F_PAD_LSB    = 8;
  localparam int F_RELU_BIT   = 12;
  localparam int F_POOL_BIT   = 13;
  localparam int F_QSHIFT_LSB = 0;

  localparam logic [3:0] KERNEL_1 = 4'd1;
  localparam logic [3:0] KERNEL_3 = 4'd3;
  localparam logic [3:0] KERNEL_5 = 4'd5;
  localparam logic [1:0] STRIDE_1 = 2'd1;
  localparam logic [1:0] STRIDE_2 = 2'd2;

  localparam logic WRITE_DIS = 1'b0;
  localparam logic WRITE_ENB = 1'b1;

  function automatic logic kernel_legal(input logic [3:0] k);
    return (k == KERNEL_1) || (k == KERNEL_3) || (k == KERNEL_5);
  endfunction

  function automatic logic stride_legal(input logic [1:0] s);
    return (s == STRIDE_1) || (s == STRIDE_2);
  endfunction

endpackage

// File: rtl/sp_ram_intf.sv
// Single-port parameter SRAM port; the compute side masters it while the
// wrapper has handed ownership to the EPU.
interface sp_ram_intf;
  logic        cs;
  logic        oe;
  logic [31:0] addr;
  logic        W_req;
  logic [31:0] W_data;
  logic [31:0] R_data;

  modport compute (output cs, output oe, output addr, output W_req, output W_data,
                   input R_data);
  modport mem (input cs, input oe, input addr, input W_req, input W_data,
               output R_data);
endinterface

// File: rtl/param_outdim.sv
// Combinational output-dimension calculator for one spatial axis, plus the
// "padded input covers the kernel" check for that axis.
module param_outdim #(
  parameter int DIM_W = 16
) (
  input  logic [DIM_W-1:0] in_dim_i,
  input  logic [3:0]       kernel_i,
  input  logic [3:0]       pad_i,
  input  logic [1:0]       stride_i,
  input  logic             pool_i,
  output logic [DIM_W-1:0] out_dim_o,
  output logic             fits_o
);

  localparam int EW = DIM_W + 2;

  logic [EW-1:0] padded;
  logic [EW-1:0] span;
  logic [EW-1:0] scaled;
  logic [1:0]    shift;

  // Two guard bits keep in + 2*pad from wrapping before the final truncation.
  always_comb begin
    padded    = EW'(in_dim_i) + EW'({pad_i, 1'b0});
    fits_o    = (padded >= EW'(kernel_i));
    span      = padded - EW'(kernel_i);
    shift     = stride_i - 2'd1;
    scaled    = (span >> shift) + EW'(1);
    out_dim_o = DIM_W'(pool_i ? (scaled >> 1) : scaled);
  end

endmodule

// File: rtl/param_loader.sv
// EPU-side parameter fetch: reads the layer's parameter words from SRAM,
// validates them and holds a registered layer configuration for the datapath.
module param_loader
  import param_loader_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int DIM_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             finish_o,
  sp_ram_intf.compute      param_bus,
  output logic             cfg_valid_o,
  output logic             err_o,
  output logic [DIM_W-1:0] in_h_o,
  output logic [DIM_W-1:0] in_w_o,
  output logic [DIM_W-1:0] in_c_o,
  output logic [DIM_W-1:0] out_c_o,
  output logic [DIM_W-1:0] out_h_o,
  output logic [DIM_W-1:0] out_w_o,
  output logic [3:0]       kernel_o,
  output logic [1:0]       stride_o,
  output logic [3:0]       pad_o,
  output logic             relu_o,
  output logic             pool_o,
  output logic [4:0]       qshift_o,
  output logic [31:0]      w_base_o,
  output logic [31:0]      b_base_o,
  output logic [31:0]      i_base_o,
  output logic [31:0]      o_base_o
);

  localparam int               CNT_W     = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NUM_WORDS - 1);

  param_loader_state_t state_q, state_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                finish_q, finish_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                err_q, err_d;
  logic                fetching;
  logic                load_cfg;
  logic                capture;
  logic [CNT_W-1:0]    cap_idx;
  logic [31:0]         words_q [NUM_WORDS];

  logic [DIM_W-1:0] f_in_h, f_in_w, f_in_c, f_out_c;
  logic [3:0]       f_kernel, f_pad;
  logic [1:0]       f_stride;
  logic             f_relu, f_pool;
  logic [4:0]       f_qshift;
  logic [DIM_W-1:0] dim_h, dim_w;
  logic             fits_h, fits_w;
  logic             cfg_ok;
  logic             unused_bits;

  logic [DIM_W-1:0] in_h_q, in_w_q, in_c_q, out_c_q, out_h_q, out_w_q;
  logic [3:0]       kernel_q, pad_q;
  logic [1:0]       stride_q;
  logic             relu_q, pool_q;
  logic [4:0]       qshift_q;
  logic [31:0]      w_base_q, b_base_q, i_base_q, o_base_q;

  assign f_in_h   = words_q[PW_DIMS0][F_DIM_LO_LSB +: DIM_W];
  assign f_in_w   = words_q[PW_DIMS0][F_DIM_HI_LSB +: DIM_W];
  assign f_in_c   = words_q[PW_DIMS1][F_DIM_LO_LSB +: DIM_W];
  assign f_out_c  = words_q[PW_DIMS1][F_DIM_HI_LSB +: DIM_W];
  assign f_kernel = words_q[PW_CTRL][F_KERNEL_LSB +: 4];
  assign f_stride = words_q[PW_CTRL][F_STRIDE_LSB +: 2];
  assign f_pad    = words_q[PW_CTRL][F_PAD_LSB +: 4];
  assign f_relu   = words_q[PW_CTRL][F_RELU_BIT];
  assign f_pool   = words_q[PW_CTRL][F_POOL_BIT];
  assign f_qshift = words_q[PW_QSHIFT][F_QSHIFT_LSB +: 5];

  assign unused_bits = ^{words_q[PW_CTRL][31:14], words_q[PW_CTRL][7:6],
                         words_q[PW_QSHIFT][31:5]};

  param_outdim #(.DIM_W(DIM_W)) u_outdim_h (
    .in_dim_i  (f_in_h),
    .kernel_i  (f_kernel),
    .pad_i     (f_pad),
    .stride_i  (f_stride),
    .pool_i    (f_pool),
    .out_dim_o (dim_h),
    .fits_o    (fits_h)
  );

  param_outdim #(.DIM_W(DIM_W)) u_outdim_w (
    .in_dim_i  (f_in_w),
    .kernel_i  (f_kernel),
    .pad_i     (f_pad),
    .stride_i  (f_stride),
    .pool_i    (f_pool),
    .out_dim_o (dim_w),
    .fits_o    (fits_w)
  );

  assign cfg_ok = kernel_legal(f_kernel) && stride_legal(f_stride) &&
                  (|f_in_h) && (|f_in_w) && (|f_in_c) && (|f_out_c) &&
                  fits_h && fits_w;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    finish_d    = 1'b0;
    cfg_valid_d = cfg_valid_q;
    err_d       = err_q;
    fetching    = 1'b0;
    load_cfg    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !finish_q) begin
          state_d     = ST_SYNC;
          rd_cnt_d    = '0;
          cfg_valid_d = 1'b0;
          err_d       = 1'b0;
        end
      end
      ST_SYNC:  state_d = ST_FETCH;
      ST_FETCH: begin
        fetching = 1'b1;
        if (rd_cnt_q == LAST_ADDR) state_d = ST_DRAIN;
        else rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
      ST_DRAIN: state_d = ST_CHECK;
      ST_CHECK: begin
        load_cfg    = 1'b1;
        cfg_valid_d = cfg_ok;
        err_d       = !cfg_ok;
        finish_d    = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (start_i) finish_d = 1'b1;
        else state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Controller withdrawing start before DONE abandons the load entirely.
    if (!start_i && (state_q inside {ST_SYNC, ST_FETCH, ST_DRAIN, ST_CHECK})) begin
      state_d     = ST_IDLE;
      cfg_valid_d = 1'b0;
      err_d       = 1'b0;
      finish_d    = 1'b0;
      load_cfg    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rd_cnt_q    <= '0;
      finish_q    <= 1'b0;
      cfg_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      finish_q    <= finish_d;
      cfg_valid_q <= cfg_valid_d;
      err_q       <= err_d;
    end
  end

  // SRAM read data lags its address by one cycle, so the capture slot trails rd_cnt.
  assign capture = ((state_q == ST_FETCH) && (rd_cnt_q != '0)) || (state_q == ST_DRAIN);
  assign cap_idx = (state_q == ST_DRAIN) ? LAST_ADDR : (rd_cnt_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
    end else if (capture) begin
      words_q[cap_idx] <= param_bus.R_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_h_q   <= '0;
      in_w_q   <= '0;
      in_c_q   <= '0;
      out_c_q  <= '0;
      out_h_q  <= '0;
      out_w_q  <= '0;
      kernel_q <= '0;
      stride_q <= '0;
      pad_q    <= '0;
      relu_q   <= 1'b0;
      pool_q   <= 1'b0;
      qshift_q <= '0;
      w_base_q <= '0;
      b_base_q <= '0;
      i_base_q <= '0;
      o_base_q <= '0;
    end else if (load_cfg) begin
      in_h_q   <= f_in_h;
      in_w_q   <= f_in_w;
      in_c_q   <= f_in_c;
      out_c_q  <= f_out_c;
      out_h_q  <= cfg_ok ? dim_h : '0;
      out_w_q  <= cfg_ok ? dim_w : '0;
      kernel_q <= f_kernel;
      stride_q <= f_stride;
      pad_q    <= f_pad;
      relu_q   <= f_relu;
      pool_q   <= f_pool;
      qshift_q <= f_qshift;
      w_base_q <= words_q[PW_WBASE];
      b_base_q <= words_q[PW_BBASE];
      i_base_q <= words_q[PW_IBASE];
      o_base_q <= words_q[PW_OBASE];
    end
  end

  assign param_bus.cs     = fetching;
  assign param_bus.oe     = fetching;
  assign param_bus.addr   = fetching ? 32'(rd_cnt_q) : 32'd0;
  assign param_bus.W_req  = WRITE_DIS;
  assign param_bus.W_data = 32'd0;

  assign finish_o    = finish_q;
  assign cfg_valid_o = cfg_valid_q;
  assign err_o       = err_q;
  assign in_h_o      = in_h_q;
  assign in_w_o      = in_w_q;
  assign in_c_o      = in_c_q;
  assign out_c_o     = out_c_q;
  assign out_h_o     = out_h_q;
  assign out_w_o     = out_w_q;
  assign kernel_o    = kernel_q;
  assign stride_o    = stride_q;
  assign pad_o       = pad_q;
  assign relu_o      = relu_q;
  assign pool_o      = pool_q;
  assign qshift_o    = qshift_q;
  assign w_base_o    = w_base_q;
  assign b_base_o    = b_base_q;
  assign i_base_o    = i_base_q;
  assign o_base_o    = o_base_q;

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader: a small synchronous SRAM model feeds
// table-driven parameter sets, plus abort, async-reset and held-start sequences.
module tb_param_loader;
  import param_loader_pkg::*;

  typedef struct {
    logic [15:0] inH, inW, inC, outC;
    logic [3:0]  kernel;
    logic [1:0]  stride;
    logic [3:0]  pad;
    logic        relu, pool;
    logic [4:0]  qshift;
    logic [15:0] expOutH, expOutW;
    logic        expValid, expErr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_i, finish_o, cfg_valid_o, err_o;
  logic [15:0] in_h_o, in_w_o, in_c_o, out_c_o, out_h_o, out_w_o;
  logic [3:0]  kernel_o, pad_o;
  logic [1:0]  stride_o;
  logic        relu_o, pool_o;
  logic [4:0]  qshift_o;
  logic [31:0] w_base_o, b_base_o, i_base_o, o_base_o;

  sp_ram_intf bus ();

  param_loader #(.NUM_WORDS(8), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .finish_o(finish_o),
    .param_bus(bus), .cfg_valid_o(cfg_valid_o), .err_o(err_o),
    .in_h_o(in_h_o), .in_w_o(in_w_o), .in_c_o(in_c_o), .out_c_o(out_c_o),
    .out_h_o(out_h_o), .out_w_o(out_w_o), .kernel_o(kernel_o),
    .stride_o(stride_o), .pad_o(pad_o), .relu_o(relu_o), .pool_o(pool_o),
    .qshift_o(qshift_o), .w_base_o(w_base_o), .b_base_o(b_base_o),
    .i_base_o(i_base_o), .o_base_o(o_base_o)
  );

  logic [31:0] mem [8];
  logic [31:0] addrLog [$];
  logic [31:0] expBase [4];
  int          wreqBad = 0;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs [13];

  always @(posedge clk) begin
    if (bus.cs && bus.oe) begin
      bus.R_data <= mem[bus.addr[2:0]];
      addrLog.push_back(bus.addr);
    end
    if (bus.W_req == WRITE_ENB) wreqBad++;
  end

  function automatic vec_t mkVec(input int inH, input int inW, input int inC, input int outC,
                                 input int k, input int s, input int p, input int relu,
                                 input int pool, input int q, input int eh, input int ew,
                                 input int ok);
    vec_t v;
    v.inH = 16'(inH);  v.inW = 16'(inW);  v.inC = 16'(inC);  v.outC = 16'(outC);
    v.kernel = 4'(k);  v.stride = 2'(s);  v.pad = 4'(p);
    v.relu = 1'(relu); v.pool = 1'(pool); v.qshift = 5'(q);
    v.expOutH = 16'(eh); v.expOutW = 16'(ew);
    v.expValid = (ok != 0); v.expErr = (ok == 0);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    mem[0] = {v.inW, v.inH};
    mem[1] = {v.outC, v.inC};
    mem[2] = {18'd0, v.pool, v.relu, v.pad, 2'b00, v.stride, v.kernel};
    mem[3] = {27'd0, v.qshift};
    for (int i = 0; i < 4; i++) begin
      expBase[i] = 32'h1000_0000 * (i + 1) + 32'(idx) * 32'h40;
      mem[4 + i] = expBase[i];
    end
  endtask

  task automatic runLoad(input vec_t v, input int idx, input int hold, input string tag);
    int cyc;
    int drops;
    int addrBad;
    applyStimulus(v, idx);
    addrLog.delete();
    start_i = 1'b1;
    tick();
    checkOutput({tag, "_sync_cs"}, 32'(bus.cs), 32'd0);
    cyc = 0;
    while (finish_o !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_finish_cycle"}, 32'(cyc), 32'd11);
    checkOutput({tag, "_cfg_valid"}, 32'(cfg_valid_o), 32'(v.expValid));
    checkOutput({tag, "_err"}, 32'(err_o), 32'(v.expErr));
    checkOutput({tag, "_out_h"}, 32'(out_h_o), 32'(v.expOutH));
    checkOutput({tag, "_out_w"}, 32'(out_w_o), 32'(v.expOutW));
    if (v.expValid) begin
      checkOutput({tag, "_dims"}, {in_w_o, in_h_o}, {v.inW, v.inH});
      checkOutput({tag, "_chans"}, {out_c_o, in_c_o}, {v.outC, v.inC});
      checkOutput({tag, "_ctrl"}, {13'd0, qshift_o, pool_o, relu_o, pad_o, stride_o, kernel_o},
                  {13'd0, v.qshift, v.pool, v.relu, v.pad, v.stride, v.kernel});
      checkOutput({tag, "_w_base"}, w_base_o, expBase[0]);
      checkOutput({tag, "_b_base"}, b_base_o, expBase[1]);
      checkOutput({tag, "_i_base"}, i_base_o, expBase[2]);
      checkOutput({tag, "_o_base"}, o_base_o, expBase[3]);
    end
    drops = 0;
    repeat (hold) begin
      tick();
      if (finish_o !== 1'b1) drops++;
    end
    checkOutput({tag, "_hold_finish_drops"}, 32'(drops), 32'd0);
    checkOutput({tag, "_fetch_count"}, 32'(addrLog.size()), 32'd8);
    addrBad = 0;
    for (int i = 0; i < addrLog.size() && i < 8; i++)
      if (addrLog[i] !== 32'(i)) addrBad++;
    checkOutput({tag, "_addr_order_errs"}, 32'(addrBad), 32'd0);
    start_i = 1'b0;
    tick();
    checkOutput({tag, "_finish_fall"}, 32'(finish_o), 32'd0);
    checkOutput({tag, "_cfg_valid_held"}, 32'(cfg_valid_o), 32'(v.expValid));
  endtask

  initial begin
    int highs;
    int logSz;
    vecs[0]  = mkVec(32, 32, 16, 32, 3, 1, 1, 1, 0, 7, 32, 32, 1);
    vecs[1]  = mkVec(28, 28, 8, 8, 5, 2, 0, 0, 1, 3, 6, 6, 1);
    vecs[2]  = mkVec(32, 32, 16, 32, 2, 1, 1, 1, 0, 7, 0, 0, 0);
    vecs[3]  = mkVec(16, 16, 4, 4, 3, 3, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mkVec(16, 16, 0, 4, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mkVec(2, 10, 4, 4, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mkVec(7, 9, 3, 5, 1, 2, 0, 1, 0, 31, 4, 5, 1);
    vecs[7]  = mkVec(1, 1, 1, 1, 3, 1, 1, 0, 0, 0, 1, 1, 1);
    vecs[8]  = mkVec(3, 4, 2, 2, 3, 1, 0, 0, 1, 1, 0, 1, 1);
    vecs[9]  = mkVec(65535, 16, 1, 1, 1, 1, 15, 0, 0, 2, 29, 46, 1);
    vecs[10] = mkVec(8, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mkVec(10, 2, 4, 4, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[12] = mkVec(8, 8, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    tick();
    tick();
    checkOutput("reset_flags", {29'd0, finish_o, cfg_valid_o, err_o}, 32'd0);
    checkOutput("reset_bus", {31'd0, bus.cs} | bus.addr, 32'd0);
    checkOutput("reset_dims", {out_w_o, out_h_o}, 32'd0);
    checkOutput("reset_kernel", 32'(kernel_o), 32'd0);
    checkOutput("reset_w_base", w_base_o, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 13; i++)
      runLoad(vecs[i], i, 0, $sformatf("vec%0d", i));

    runLoad(vecs[1], 1, 20, "held_start");

    applyStimulus(vecs[0], 0);
    start_i = 1'b1;
    repeat (5) tick();
    checkOutput("abort_pre_cs", 32'(bus.cs), 32'd1);
    start_i = 1'b0;
    tick();
    checkOutput("abort_cs", 32'(bus.cs), 32'd0);
    checkOutput("abort_flags", {30'd0, cfg_valid_o, err_o}, 32'd0);
    highs = 0;
    repeat (5) begin
      tick();
      if (finish_o !== 1'b0) highs++;
    end
    checkOutput("abort_no_finish", 32'(highs), 32'd0);
    runLoad(vecs[0], 0, 0, "after_abort");

    applyStimulus(vecs[6], 6);
    start_i = 1'b1;
    repeat (4) tick();
    checkOutput("rst_pre_cs", 32'(bus.cs), 32'd1);
    #3 rst = 1'b0;
    #1;
    checkOutput("rst_async_bus", {31'd0, bus.cs} | bus.addr, 32'd0);
    checkOutput("rst_async_flags", {29'd0, finish_o, cfg_valid_o, err_o}, 32'd0);
    checkOutput("rst_async_out_h", 32'(out_h_o), 32'd0);
    checkOutput("rst_async_w_base", w_base_o, 32'd0);
    start_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    logSz = addrLog.size();
    repeat (6) tick();
    checkOutput("rst_idle_no_fetch", 32'(addrLog.size()), 32'(logSz));
    checkOutput("rst_idle_flags", {30'd0, finish_o, bus.cs}, 32'd0);
    runLoad(vecs[6], 6, 0, "after_reset");

    checkOutput("wreq_never_enb", 32'(wreqBad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
